// File: rtl/sample_stream_fifo.sv
// First-word-fall-through ready/valid FIFO with occupancy level, almost-full
// flag and wrapping input/output transfer counters.
module sample_stream_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = DEPTH - 1,
  parameter int CNT_WIDTH   = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stream_in_valid,
  output logic                  stream_in_ready,
  input  logic [DATA_WIDTH-1:0] stream_in_data,
  output logic                  stream_out_valid,
  input  logic                  stream_out_ready,
  output logic [DATA_WIDTH-1:0] stream_out_data,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic [CNT_WIDTH-1:0]  in_count,
  output logic [CNT_WIDTH-1:0]  out_count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Ready depends only on registered state and reset, never on valid.
  assign stream_in_ready  = (level != LW'(DEPTH)) && !reset;
  assign stream_out_valid = (level != '0);
  assign stream_out_data  = mem[rd_ptr];
  assign almost_full      = (level >= LW'(ALMOST_FULL));

  assign push = stream_in_valid && stream_in_ready;
  assign pop  = stream_out_valid && stream_out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        in_count <= in_count + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_count <= out_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; level alone decides which entries are live,
  // which keeps the array a plain RAM with no reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= stream_in_data;
    end
  end

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Self-checking bench for sample_stream_fifo: a cycle model plus a data
// scoreboard queue drives every expectation.
module tb_sample_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          stream_in_valid;
  logic          stream_in_ready;
  logic [DW-1:0] stream_in_data;
  logic          stream_out_valid;
  logic          stream_out_ready;
  logic [DW-1:0] stream_out_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic [CW-1:0] in_count;
  logic [CW-1:0] out_count;

  sample_stream_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ALMOST_FULL(AF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stream_in_valid (stream_in_valid),
    .stream_in_ready (stream_in_ready),
    .stream_in_data  (stream_in_data),
    .stream_out_valid(stream_out_valid),
    .stream_out_ready(stream_out_ready),
    .stream_out_data (stream_out_data),
    .level           (level),
    .almost_full     (almost_full),
    .in_count        (in_count),
    .out_count       (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [DW-1:0] sb_q[$];
  int            m_level = 0;
  logic [CW-1:0] m_in    = '0;
  logic [CW-1:0] m_out   = '0;
  int            max_stream_level;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // then advance the model across the next rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] d,
                       input logic r);
    logic exp_ready, exp_valid, m_push, m_pop;
    reset            = rst;
    stream_in_valid  = v;
    stream_in_data   = d;
    stream_out_ready = r;
    #1;
    exp_ready = !rst && (m_level != DEPTH);
    exp_valid = (m_level != 0);
    check("in_ready",    32'(stream_in_ready),  32'(exp_ready));
    check("out_valid",   32'(stream_out_valid), 32'(exp_valid));
    check("level",       32'(level),            32'(m_level));
    check("almost_full", 32'(almost_full),      32'(m_level >= AF));
    check("in_count",    32'(in_count),         32'(m_in));
    check("out_count",   32'(out_count),        32'(m_out));
    check("count_diff",  32'(CW'(in_count - out_count)), 32'(level));
    if (exp_valid && sb_q.size() > 0)
      check("out_data", 32'(stream_out_data), 32'(sb_q[0]));
    m_push = v && exp_ready;
    m_pop  = exp_valid && r;
    if (rst) begin
      sb_q.delete();
      m_level = 0;
      m_in    = '0;
      m_out   = '0;
    end else begin
      if (m_pop) begin
        void'(sb_q.pop_front());
        m_out = m_out + 1'b1;
        m_level--;
      end
      if (m_push) begin
        sb_q.push_back(d);
        m_in = m_in + 1'b1;
        m_level++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset            = 1'b1;
    stream_in_valid  = 1'b1;
    stream_in_data   = 8'hEE;
    stream_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with valid asserted: nothing accepted.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill to full with the output stalled, then drain.
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    cycle(1'b0, 1'b1, 8'h33, 1'b0);
    cycle(1'b0, 1'b1, 8'h44, 1'b0);
    cycle(1'b0, 1'b1, 8'h55, 1'b0);  // refused: full
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_level", 32'(level), 32'd0);
    check("drain_in_count", 32'(in_count), 32'(m_in));

    // Full-rate streaming.
    max_stream_level = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b1);
      if (int'(level) > max_stream_level) max_stream_level = int'(level);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_max_level", 32'(max_stream_level), 32'd1);

    // Full with simultaneous pop, then push+pop at level 3; pointers wrap.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
    cycle(1'b0, 1'b1, 8'hD0, 1'b1);  // pop only
    check("full_pop_level", 32'(level), 32'd3);
    cycle(1'b0, 1'b1, 8'hD1, 1'b1);  // push and pop
    check("push_pop_level", 32'(level), 32'd3);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Random backpressure; counters wrap many times.
    for (int i = 0; i < 1000; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("random_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-operation at level 3.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 8'h99, 1'b1);
    check("post_reset_level", 32'(level), 32'd0);
    check("post_reset_valid", 32'(stream_out_valid), 32'd0);
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    check("a5_head", 32'(stream_out_data), 32'hA5);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
